// File: rtl/sr_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits MSB-first, one even-parity bit.
// Good words land in a one-entry valid/ready buffer; parity errors and overflows are flagged.
module sr_frame_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              si,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              par_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              par_err_q, par_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              par_ok;
  logic              buf_free;

  assign par_ok   = ~(^shreg_q ^ si);
  assign buf_free = ~out_valid_q | out_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    par_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    ovf_d       = ovf_q & ~ovf_clr;

    unique case (state_q)
      IDLE: begin
        if (si) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        shreg_d   = {shreg_q[DATA_W-2:0], si};
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == CW'(DATA_W - 1)) state_d = PARITY;
      end
      PARITY: begin
        state_d = IDLE;
        if (par_ok) begin
          if (buf_free) begin
            out_data_d  = shreg_q;
            out_valid_d = 1'b1;
          end else begin
            // set wins over a simultaneous ovf_clr
            ovf_d = 1'b1;
          end
        end else begin
          par_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      par_err_q   <= par_err_d;
      err_cnt_q   <= err_cnt_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign par_err   = par_err_q;
  assign err_cnt   = err_cnt_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sr_frame_rx.sv
// Directed bench for sr_frame_rx with DATA_W=4, CNT_W=2.
module tb_sr_frame_rx;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              si;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              par_err;
  logic [CNT_W-1:0]  err_cnt;
  logic              ovf;
  logic              ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  sr_frame_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .si        (si),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .par_err   (par_err),
    .err_cnt   (err_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full frame; optionally raises out_ready alongside the parity bit.
  task automatic send(input logic [DATA_W-1:0] data, input logic p, input logic rdy_at_par);
    si = 1'b1;
    tick();
    for (int i = DATA_W - 1; i >= 0; i--) begin
      si = data[i];
      tick();
    end
    if (rdy_at_par) out_ready = 1'b1;
    si = p;
    tick();
    si = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; si = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_perr",  32'(par_err),   32'd0);
    check("rst_ecnt",  32'(err_cnt),   32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // 1: good frame, consumer ready
    out_ready = 1'b1;
    send(4'b1010, 1'b0, 1'b0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'hA);
    check("t1_perr",  32'(par_err),   32'd0);
    check("t1_busy",  32'(busy),      32'd0);
    tick();
    check("t1_drain", 32'(out_valid), 32'd0);

    // 2: bad parity
    send(4'b0111, 1'b0, 1'b0);
    check("t2_perr",  32'(par_err),   32'd1);
    check("t2_ecnt",  32'(err_cnt),   32'd1);
    check("t2_valid", 32'(out_valid), 32'd0);
    tick();
    check("t2_pulse", 32'(par_err),   32'd0);

    // 3: counter saturation
    for (int k = 0; k < 4; k++) begin
      send(4'b0001, 1'b0, 1'b0);
      check("t3_ecnt", 32'(err_cnt), (k >= 1) ? 32'd3 : 32'd2);
      check("t3_perr", 32'(par_err), 32'd1);
    end

    // 4: overflow with stalled consumer, back-to-back frames
    out_ready = 1'b0;
    send(4'b1010, 1'b0, 1'b0);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_ovf0",  32'(ovf),       32'd0);
    send(4'b0011, 1'b0, 1'b0);
    check("t4_data",  32'(out_data),  32'hA);
    check("t4_ovf1",  32'(ovf),       32'd1);
    check("t4_ecnt",  32'(err_cnt),   32'd3);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovfclr", 32'(ovf), 32'd0);
    check("t4_hold",   32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("t4_drain", 32'(out_valid), 32'd0);

    // 5: drain and reload on the same edge
    out_ready = 1'b0;
    send(4'b1100, 1'b0, 1'b0);
    check("t5_data0", 32'(out_data), 32'hC);
    send(4'b0101, 1'b0, 1'b1);
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_data1", 32'(out_data),  32'h5);
    check("t5_ovf",   32'(ovf),       32'd0);
    tick();
    check("t5_drain", 32'(out_valid), 32'd0);

    // 6: async reset mid-frame with buffered word and ovf set
    out_ready = 1'b0;
    send(4'b1001, 1'b0, 1'b0);
    send(4'b1111, 1'b0, 1'b0);
    check("t6_ovf", 32'(ovf), 32'd1);
    si = 1'b1; tick();
    si = 1'b1; tick();
    si = 1'b0; tick();
    check("t6_busy1", 32'(busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_busy",  32'(busy),      32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data",  32'(out_data),  32'd0);
    check("t6_ecnt",  32'(err_cnt),   32'd0);
    check("t6_ovf0",  32'(ovf),       32'd0);
    check("t6_perr",  32'(par_err),   32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("t6_idle", 32'(busy), 32'd0);
    out_ready = 1'b1;
    send(4'b0110, 1'b0, 1'b0);
    check("t6_rxv", 32'(out_valid), 32'd1);
    check("t6_rxd", 32'(out_data),  32'h6);
    check("t6_rxe", 32'(par_err),   32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
